load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-wide, byte-enabled data memory.
// Define LSU_MISALIGN_SPLIT_EN to run word-crossing accesses as two memory cycles; otherwise they are rejected.
module load_store_unit #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;

  localparam logic [MEM_AW-1:0] ADR_ONE = 1;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              split_q, split_d;
  logic [3:0]        we_hi_q, we_hi_d;
  logic [31:0]       wdata_hi_q, wdata_hi_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_adr_q, mem_adr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]  req_off;
  logic [3:0]  req_size;
  logic [3:0]  req_mask;
  logic        req_cross;
  logic        req_bad;
  logic [7:0]  req_be;
  logic [63:0] req_wd;
  logic [63:0] ld_data;
  logic [63:0] ld_shift;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;
  logic        addr_unused;

  // Address bits above the memory window are don't-care.
  assign addr_unused = ^req_addr[31:MEM_AW+2];

  always_comb begin
    req_off = req_addr[1:0];
    case (req_funct3[1:0])
      2'b00:   begin req_size = 4'd1; req_mask = 4'b0001; end
      2'b01:   begin req_size = 4'd2; req_mask = 4'b0011; end
      default: begin req_size = 4'd4; req_mask = 4'b1111; end
    endcase
    req_cross = ({2'b00, req_off} + req_size) > 4'd4;
    req_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_funct3[2] && req_we);
`ifndef LSU_MISALIGN_SPLIT_EN
    req_bad = req_bad || (req_funct3[1:0] == 2'b01 && req_off[0]) ||
              (req_funct3[1:0] == 2'b10 && req_off != 2'b00);
`endif
    req_be = {4'b0000, req_mask} << req_off;
    req_wd = {32'h0, req_wdata} << {req_off, 3'b000};
  end

  // For a split load the low lanes come from word A (buffered) and the rest from word A+1.
  always_comb begin
    ld_data  = split_q ? {mem_rdata, rbuf_q} : {32'h0, mem_rdata};
    ld_shift = ld_data >> {off_q, 3'b000};
    ld_word  = ld_shift[31:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    split_d     = split_q;
    we_hi_d     = we_hi_q;
    wdata_hi_d  = wdata_hi_q;
    rbuf_d      = rbuf_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          off_d      = req_off;
          split_d    = req_cross;
          we_hi_d    = req_we ? req_be[7:4] : 4'b0000;
          wdata_hi_d = req_wd[63:32];
          if (req_bad) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d     = ACC0;
            mem_en_d    = 1'b1;
            mem_adr_d   = req_addr[MEM_AW+1:2];
            mem_we_d    = req_we ? req_be[3:0] : 4'b0000;
            mem_wdata_d = req_wd[31:0];
          end
        end
      end
      ACC0: begin
        if (split_q) begin
          state_d     = ACC1;
          mem_en_d    = 1'b1;
          mem_adr_d   = mem_adr_q + ADR_ONE;
          mem_we_d    = we_hi_q;
          mem_wdata_d = wdata_hi_q;
        end else if (we_q) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d = WAIT;
        end
      end
      ACC1: begin
        rbuf_d = mem_rdata;
        if (we_q) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d     = RESP;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ld_ext;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      split_q     <= 1'b0;
      we_hi_q     <= 4'b0000;
      wdata_hi_q  <= 32'h0;
      rbuf_q      <= 32'h0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_adr_q   <= '0;
      mem_wdata_q <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      split_q     <= split_d;
      we_hi_q     <= we_hi_d;
      wdata_hi_q  <= wdata_hi_d;
      rbuf_q      <= rbuf_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences and random traffic
// checked against a byte-array reference model. Follows LSU_MISALIGN_SPLIT_EN when defined.
module tb_load_store_unit;
  localparam int MEM_AW = 12;
  localparam int NBYTES = 4 << MEM_AW;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_adr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [MEM_AW-1:0] adr;
    logic [3:0]        we;
    logic [31:0]       wdata;
  } bus_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nen;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic        tb_active = 1'b0;
  logic [31:0] dmem [0:(1<<MEM_AW)-1];
  logic [7:0]  ref_mem [0:NBYTES-1];
  bus_t        bus_log[$];
  vec_t        vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External byte-enabled memory; read data appears the cycle after mem_en, garbage on store cycles.
  always @(posedge clk) begin
    bus_t        e;
    logic [31:0] w;
    if (mem_en) begin
      e.adr = mem_adr;
      e.we = mem_we;
      e.wdata = mem_wdata;
      bus_log.push_back(e);
      w = dmem[mem_adr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
      dmem[mem_adr] <= w;
      mem_rdata <= (mem_we != 4'b0000) ? $urandom : dmem[mem_adr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (tb_active && !mem_en) checkOutput("we_without_en", 32'(mem_we), 32'h0);

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: byte-addressed memory, natural-alignment rule when splitting is off.
  task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output logic err, output int lat, output int nen);
    int          o;
    int          size;
    int          base;
    logic [31:0] v;
    o = int'(addr[1:0]);
    base = int'(addr[MEM_AW+1:0]);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && we);
`ifndef LSU_MISALIGN_SPLIT_EN
    if (o % size != 0) err = 1'b1;
`endif
    rdata = 32'h0;
    if (err) begin
      lat = 1;
      nen = 0;
    end else begin
      nen = (o + size > 4) ? 2 : 1;
      lat = (we ? 2 : 3) + nen - 1;
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[(base + i) % NBYTES] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(base + i) % NBYTES];
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rdata = v;
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("req_ready_before_req", 32'(req_ready), 32'h1);
    bus_log.delete();
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    rdata = 32'h0;
    err = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        rdata = rsp_rdata;
        err = rsp_err;
        break;
      end
    end
    @(negedge clk);
    checkOutput("rsp_single_pulse", 32'(rsp_valid), 32'h0);
  endtask

  function automatic vec_t mkVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_lat, input int exp_nen);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_nen = exp_nen;
    return v;
  endfunction

  initial begin
    logic [31:0] a_rdata;
    logic [31:0] m_rdata;
    logic        a_err;
    logic        m_err;
    int          a_lat;
    int          m_lat;
    int          m_nen;
    int          seen;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;

    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    rst = 1'b1;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_mem_en", 32'(mem_en), 32'h0);
    checkOutput("reset_mem_adr", 32'(mem_adr), 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    tb_active = 1'b1;

    // SW / SB bus-level checks.
    applyStimulus(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, a_rdata, a_err, a_lat);
    modelAccess(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, m_rdata, m_err, m_lat, m_nen);
    checkOutput("sw104_lat", 32'(a_lat), 32'd2);
    checkOutput("sw104_err", 32'(a_err), 32'h0);
    checkOutput("sw104_nen", 32'(bus_log.size()), 32'd1);
    checkOutput("sw104_adr", 32'(bus_log[0].adr), 32'h041);
    checkOutput("sw104_we", 32'(bus_log[0].we), 32'hF);
    checkOutput("sw104_wdata", bus_log[0].wdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'b000, 32'h105, 32'h000000A5, a_rdata, a_err, a_lat);
    modelAccess(1'b1, 3'b000, 32'h105, 32'h000000A5, m_rdata, m_err, m_lat, m_nen);
    checkOutput("sb105_lat", 32'(a_lat), 32'd2);
    checkOutput("sb105_we", 32'(bus_log[0].we), 32'h2);
    checkOutput("sb105_wdata", bus_log[0].wdata, 32'h0000A500);

    vecs.push_back(mkVec(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1));
    vecs.push_back(mkVec(1'b1, 3'b000, 32'h105, 32'h000000A5, 32'h0, 1'b0, 2, 1));
    vecs.push_back(mkVec(1'b0, 3'b000, 32'h105, 32'h0, 32'hFFFFFFA5, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b0, 3'b100, 32'h105, 32'h0, 32'h000000A5, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFFDEAD, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b0, 3'b101, 32'h106, 32'h0, 32'h0000DEAD, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b0, 3'b011, 32'h104, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mkVec(1'b1, 3'b010, 32'h108, 32'h01234567, 32'h0, 1'b0, 2, 1));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mkVec(1'b0, 3'b010, 32'h107, 32'h0, 32'h234567DE, 1'b0, 4, 2));
`else
    vecs.push_back(mkVec(1'b0, 3'b010, 32'h107, 32'h0, 32'h0, 1'b1, 1, 0));
`endif
    vecs.push_back(mkVec(1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADA5EF, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b1, 3'b100, 32'h104, 32'h55, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mkVec(1'b0, 3'b110, 32'h104, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mkVec(1'b1, 3'b111, 32'h104, 32'h0, 32'h0, 1'b1, 1, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h105, 32'h0, 32'hFFFFADA5, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h107, 32'h0, 32'h000067DE, 1'b0, 4, 2));
`else
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h105, 32'h0, 32'h0, 1'b1, 1, 0));
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h107, 32'h0, 32'h0, 1'b1, 1, 0));
`endif
    vecs.push_back(mkVec(1'b0, 3'b000, 32'h10B, 32'h0, 32'h00000001, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b1, 3'b001, 32'h10A, 32'hFFFF8001, 32'h0, 1'b0, 2, 1));
    vecs.push_back(mkVec(1'b0, 3'b001, 32'h10A, 32'h0, 32'hFFFF8001, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b0, 3'b101, 32'h10A, 32'h0, 32'h00008001, 1'b0, 3, 1));
    vecs.push_back(mkVec(1'b0, 3'b010, 32'hABC00108, 32'h0, 32'h80014567, 1'b0, 3, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, a_rdata, a_err, a_lat);
      modelAccess(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rdata, m_err, m_lat, m_nen);
      checkOutput($sformatf("tbl%0d_rdata", i), a_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("tbl%0d_err", i), 32'(a_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("tbl%0d_lat", i), 32'(a_lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("tbl%0d_nen", i), 32'(bus_log.size()), 32'(vecs[i].exp_nen));
    end

    // Prefill every word the random phase can reach.
    for (int w = 0; w < 20; w++) begin
      addr = (w < 16) ? 32'(32'h100 + 4*w) : 32'(32'h3FF8 + 4*(w - 16));
      wdata = $urandom;
      applyStimulus(1'b1, 3'b010, addr, wdata, a_rdata, a_err, a_lat);
      modelAccess(1'b1, 3'b010, addr[13:0], wdata, m_rdata, m_err, m_lat, m_nen);
      checkOutput($sformatf("fill%0d_err", w), 32'(a_err), 32'(m_err));
      checkOutput($sformatf("fill%0d_lat", w), 32'(a_lat), 32'(m_lat));
    end

    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) addr = 32'h3FF8 + 32'($urandom_range(0, 11));
      else addr = 32'h100 + 32'($urandom_range(0, 59));
      addr[31:14] = 18'($urandom);
      wdata = $urandom;
      applyStimulus(we, f3, addr, wdata, a_rdata, a_err, a_lat);
      modelAccess(we, f3, addr, wdata, m_rdata, m_err, m_lat, m_nen);
      checkOutput($sformatf("rnd%0d_rdata", n), a_rdata, m_rdata);
      checkOutput($sformatf("rnd%0d_err", n), 32'(a_err), 32'(m_err));
      checkOutput($sformatf("rnd%0d_lat", n), 32'(a_lat), 32'(m_lat));
      checkOutput($sformatf("rnd%0d_nen", n), 32'(bus_log.size()), 32'(m_nen));
    end

    // Word-crossing store at the top of memory wraps to word 0.
    applyStimulus(1'b1, 3'b010, 32'h3FFE, 32'h11223344, a_rdata, a_err, a_lat);
    modelAccess(1'b1, 3'b010, 32'h3FFE, 32'h11223344, m_rdata, m_err, m_lat, m_nen);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("wrap_err", 32'(a_err), 32'h0);
    checkOutput("wrap_lat", 32'(a_lat), 32'd3);
    checkOutput("wrap_nen", 32'(bus_log.size()), 32'd2);
    checkOutput("wrap_adr0", 32'(bus_log[0].adr), 32'hFFF);
    checkOutput("wrap_we0", 32'(bus_log[0].we), 32'hC);
    checkOutput("wrap_wdata0", bus_log[0].wdata, 32'h33440000);
    checkOutput("wrap_adr1", 32'(bus_log[1].adr), 32'h000);
    checkOutput("wrap_we1", 32'(bus_log[1].we), 32'h3);
    checkOutput("wrap_wdata1", bus_log[1].wdata, 32'h00001122);
    applyStimulus(1'b0, 3'b010, 32'h107, 32'h0, a_rdata, a_err, a_lat);
    modelAccess(1'b0, 3'b010, 32'h107, 32'h0, m_rdata, m_err, m_lat, m_nen);
    checkOutput("lw107_rdata", a_rdata, m_rdata);
    checkOutput("lw107_adr0", 32'(bus_log[0].adr), 32'h041);
    checkOutput("lw107_adr1", 32'(bus_log[1].adr), 32'h042);
    checkOutput("lw107_we1", 32'(bus_log[1].we), 32'h0);
`else
    checkOutput("wrap_err", 32'(a_err), 32'h1);
    checkOutput("wrap_lat", 32'(a_lat), 32'd1);
    checkOutput("wrap_nen", 32'(bus_log.size()), 32'd0);
`endif

    // Load leaves a non-zero response behind, then reset hits the WAIT cycle of another load.
    applyStimulus(1'b0, 3'b010, 32'h104, 32'h0, a_rdata, a_err, a_lat);
    modelAccess(1'b0, 3'b010, 32'h104, 32'h0, m_rdata, m_err, m_lat, m_nen);
    checkOutput("pre_rst_rdata", a_rdata, m_rdata);
    @(negedge clk);
    bus_log.delete();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("midrst_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("midrst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("midrst_mem_en", 32'(mem_en), 32'h0);
    checkOutput("midrst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("midrst_mem_adr", 32'(mem_adr), 32'h0);
    checkOutput("midrst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("midrst_no_rsp", 32'(seen), 32'h0);
    checkOutput("midrst_no_more_en", 32'(bus_log.size()), 32'd1);
    checkOutput("midrst_ready", 32'(req_ready), 32'h1);
    applyStimulus(1'b0, 3'b010, 32'h104, 32'h0, a_rdata, a_err, a_lat);
    checkOutput("post_rst_rdata", a_rdata, m_rdata);
    checkOutput("post_rst_lat", 32'(a_lat), 32'd3);
    repeat (3) @(negedge clk);
    checkOutput("rdata_hold", rsp_rdata, m_rdata);

    tb_active = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
